// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Bundles the serial line and receive-side outputs of the UART receiver.
//   slave  : the receiver (samples i_RX_Serial, drives the byte/strobe/status)
//   master : the environment (drives i_RX_Serial, observes the outputs)
//   Signals:
//     i_RX_Serial  raw asynchronous serial line, idle high
//     o_RX_DV      one-cycle strobe, o_RX_Byte holds a new valid byte
//     o_RX_Byte    last correctly framed byte
//     o_Frame_Err  one-cycle strobe, stop bit sampled low
//     o_Busy       receiver state machine is not idle
interface uart_rx_if;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_Frame_Err;
  logic       o_Busy;

  modport master (
    output i_RX_Serial,
    input  o_RX_DV,
    input  o_RX_Byte,
    input  o_Frame_Err,
    input  o_Busy
  );

  modport slave (
    input  i_RX_Serial,
    output o_RX_DV,
    output o_RX_Byte,
    output o_Frame_Err,
    output o_Busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver, LSB first. Recovers bytes from an asynchronous serial
//   line using the system clock, strobes each good byte for one cycle and
//   strobes a framing error when the stop bit is low.
//   Parameters:
//     CLKS_PER_BIT  system clocks per serial bit (4..65535)
//   Ports:
//     i_Clock  system clock, rising edge
//     i_Reset  asynchronous active-high reset
//     rx_if    uart_rx_if.slave: serial in, byte/strobes/busy out
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | line idle, waiting for synchronized line to go low
//   S_START | timing to the middle of the start bit, reject glitches
//   S_DATA  | sampling 8 data bits one bit period apart
//   S_STOP  | sampling the stop bit, emitting byte or framing error
//   S_BREAK | line held low after a bad stop bit, wait for it to go high
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_rx_if.slave  rx_if
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          sync1_q, sync2_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          fe_q, fe_d;

  // Two-flop synchronizer; resets to the idle (high) line level so a
  // reset release on an idle line never looks like a start edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_if.i_RX_Serial;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF) begin
          // Mid start bit: still low means a real frame, high means a glitch.
          if (!rx_s) begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == LAST) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_if.o_RX_DV     = dv_q;
  assign rx_if.o_RX_Byte   = byte_q;
  assign rx_if.o_Frame_Err = fe_q;
  assign rx_if.o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Directed bench for uart_rx at CLKS_PER_BIT=16 (H=7, strobe latency 154
//   clocks from the first low edge). The serial line is driven on falling
//   clock edges; a monitor on falling edges logs strobes with cycle stamps.
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk;
  logic rst;
  int   cyc;
  int   r_cyc;
  int   n_checks;
  int   n_fail;

  int   dv_bytes[$];
  int   dv_cycs[$];
  int   fe_cnt;
  int   overlap_cnt;
  logic busy_seen;

  uart_rx_if rx_bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx_if   (rx_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    fe_cnt      = 0;
    overlap_cnt = 0;
    busy_seen   = 1'b0;
  end

  always @(negedge clk) begin
    if (rx_bus.o_RX_DV) begin
      dv_bytes.push_back(int'(rx_bus.o_RX_Byte));
      dv_cycs.push_back(cyc);
    end
    if (rx_bus.o_Frame_Err) fe_cnt++;
    if (rx_bus.o_RX_DV && rx_bus.o_Frame_Err) overlap_cnt++;
    if (rx_bus.o_Busy) busy_seen = 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives n clocks of a 10-bit frame (bit 0 = start) with a possibly
  // non-integer bit period, one value per falling edge.
  task automatic send_clks(input logic [9:0] frame, input real period, input int n);
    int bi;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bi = int'($floor(real'(c) / period));
      if (bi > 9) bi = 9;
      rx_bus.i_RX_Serial = frame[bi];
      if (c == 0) r_cyc = cyc + 1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input real period);
    send_clks({stop, data, 1'b0}, period, int'($ceil(10.0 * period)));
  endtask

  task automatic idle_clks(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rx_bus.i_RX_Serial = 1'b1;
    end
  endtask

  int base;
  int exp_fe;
  int r0;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    r_cyc    = 0;
    rx_bus.i_RX_Serial = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_dv",   rx_bus.o_RX_DV,     0);
    check_val("rst_byte", rx_bus.o_RX_Byte,   8'h00);
    check_val("rst_fe",   rx_bus.o_Frame_Err, 0);
    check_val("rst_busy", rx_bus.o_Busy,      0);
    rst = 1'b0;
    idle_clks(10);

    // Single byte with exact latency
    send_frame(8'hA5, 1'b1, 16.0);
    idle_clks(20);
    check_val("a5_count", dv_bytes.size(), 1);
    if (dv_bytes.size() >= 1) begin
      check_val("a5_byte",    dv_bytes[0], 8'hA5);
      check_val("a5_latency", dv_cycs[0] - r_cyc, 154);
    end
    check_val("a5_fe", fe_cnt, 0);
    check_val("a5_busy_seen", busy_seen, 1);
    check_val("a5_idle", rx_bus.o_Busy, 0);

    // Back-to-back, no idle gap
    base = dv_bytes.size();
    send_frame(8'h00, 1'b1, 16.0);
    r0 = r_cyc;
    send_frame(8'hFF, 1'b1, 16.0);
    send_frame(8'h5A, 1'b1, 16.0);
    idle_clks(30);
    check_val("b2b_count", dv_bytes.size() - base, 3);
    if (dv_bytes.size() >= base + 3) begin
      check_val("b2b_byte0", dv_bytes[base],     8'h00);
      check_val("b2b_byte1", dv_bytes[base + 1], 8'hFF);
      check_val("b2b_byte2", dv_bytes[base + 2], 8'h5A);
      check_val("b2b_lat0",  dv_cycs[base] - r0, 154);
      check_val("b2b_gap01", dv_cycs[base + 1] - dv_cycs[base], 160);
      check_val("b2b_gap12", dv_cycs[base + 2] - dv_cycs[base + 1], 160);
    end
    check_val("b2b_fe", fe_cnt, 0);

    // Framing error, line held low 40 clocks then released
    base = dv_bytes.size();
    send_frame(8'h3C, 1'b0, 16.0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rx_bus.i_RX_Serial = 1'b0;
    end
    check_val("fe_count",  fe_cnt, 1);
    check_val("fe_no_dv",  dv_bytes.size() - base, 0);
    check_val("fe_byte_kept", rx_bus.o_RX_Byte, 8'h5A);
    check_val("fe_busy_low_line", rx_bus.o_Busy, 1);
    @(negedge clk);
    rx_bus.i_RX_Serial = 1'b1;
    repeat (2) @(negedge clk);
    check_val("fe_busy_rel2", rx_bus.o_Busy, 1);
    @(negedge clk);
    check_val("fe_busy_rel3", rx_bus.o_Busy, 0);
    idle_clks(200);
    check_val("fe_no_spur_dv", dv_bytes.size() - base, 0);
    check_val("fe_no_spur_fe", fe_cnt, 1);
    check_val("fe_spur_busy",  rx_bus.o_Busy, 0);

    // Glitch: 4-clock low pulse
    base      = dv_bytes.size();
    exp_fe    = fe_cnt;
    busy_seen = 1'b0;
    @(negedge clk);
    rx_bus.i_RX_Serial = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rx_bus.i_RX_Serial = 1'b1;
    repeat (8) @(negedge clk);
    check_val("gl_busy_low", rx_bus.o_Busy, 0);
    check_val("gl_busy_seen", busy_seen, 1);
    idle_clks(200);
    check_val("gl_no_dv", dv_bytes.size() - base, 0);
    check_val("gl_no_fe", fe_cnt, exp_fe);

    // Reset during data bit 3 of 8'hC3, then a clean 8'h81
    base = dv_bytes.size();
    send_clks({1'b1, 8'hC3, 1'b0}, 16.0, 72);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("mr_dv",   rx_bus.o_RX_DV,     0);
    check_val("mr_byte", rx_bus.o_RX_Byte,   8'h00);
    check_val("mr_fe",   rx_bus.o_Frame_Err, 0);
    check_val("mr_busy", rx_bus.o_Busy,      0);
    rx_bus.i_RX_Serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_clks(200);
    check_val("mr_no_partial", dv_bytes.size() - base, 0);
    send_frame(8'h81, 1'b1, 16.0);
    idle_clks(30);
    check_val("mr_count", dv_bytes.size() - base, 1);
    if (dv_bytes.size() >= base + 1) check_val("mr_byte81", dv_bytes[base], 8'h81);
    check_val("mr_no_fe", fe_cnt, exp_fe);

    // Baud skew +3% / -3%
    base = dv_bytes.size();
    send_frame(8'h96, 1'b1, 16.48);
    idle_clks(30);
    send_frame(8'h96, 1'b1, 15.52);
    idle_clks(30);
    check_val("sk_count", dv_bytes.size() - base, 2);
    if (dv_bytes.size() >= base + 2) begin
      check_val("sk_slow_byte", dv_bytes[base],     8'h96);
      check_val("sk_fast_byte", dv_bytes[base + 1], 8'h96);
    end
    check_val("sk_no_fe", fe_cnt, exp_fe);

    check_val("dv_fe_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
